// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit for the Execute stage: shift-add multiply,
// restoring divide, one bit per cycle, with fast paths for divide-by-zero and signed overflow.
module mdu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        StartE,
  input  logic        FlushE,
  input  logic [2:0]  Funct3E,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        StallMdvE,
  output logic        MdvValidE,
  output logic [31:0] MdvResultE,
  output logic [1:0]  state_dbg
);

  // Handshake: an op is accepted in IDLE when StartE=1 and FlushE=0; StallMdvE holds the
  // pipeline until the single DONE cycle, where MdvValidE=1 qualifies MdvResultE.
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op;
  logic [4:0]  cnt;
  logic [63:0] acc;       // MUL: {product hi, multiplier/product lo}; DIV: {remainder, quotient}
  logic [31:0] opb;       // multiplicand or divisor magnitude
  logic        neg;       // sign to apply to the selected result

  logic        accept, fast, a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, fast_res, q_fix, r_fix, fin;
  logic [32:0] sum33, trial;
  logic [63:0] acc_mul, acc_div, prod_fix;

  assign state_dbg = state;

  always_comb begin
    a_signed = Funct3E[2] ? ~Funct3E[0] : ~(Funct3E[1] & Funct3E[0]);
    b_signed = Funct3E[2] ? ~Funct3E[0] : ~Funct3E[1];
    a_neg    = a_signed & SrcAE[31];
    b_neg    = b_signed & SrcBE[31];
    a_mag    = a_neg ? (~SrcAE + 32'd1) : SrcAE;
    b_mag    = b_neg ? (~SrcBE + 32'd1) : SrcBE;
    fast     = 1'b0;
    fast_res = 32'd0;
    if (Funct3E[2] && SrcBE == 32'd0) begin
      fast     = 1'b1;
      fast_res = Funct3E[1] ? SrcAE : 32'hFFFF_FFFF;
    end else if (Funct3E[2] && !Funct3E[0] && SrcAE == 32'h8000_0000 && SrcBE == 32'hFFFF_FFFF) begin
      fast     = 1'b1;
      fast_res = Funct3E[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration of each algorithm; the final iteration's result feeds sign correction.
  always_comb begin
    sum33    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    acc_mul  = {sum33, acc[31:1]};
    trial    = {acc[63:32], acc[31]} - {1'b0, opb};
    acc_div  = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
    prod_fix = neg ? (~acc_mul + 64'd1) : acc_mul;
    q_fix    = neg ? (~acc_div[31:0] + 32'd1) : acc_div[31:0];
    r_fix    = neg ? (~acc_div[63:32] + 32'd1) : acc_div[63:32];
    if (state == MUL) fin = (op[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
    else              fin = op[1] ? r_fix : q_fix;
  end

  always_comb begin
    state_nxt = state;
    StallMdvE = 1'b0;
    MdvValidE = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: if (StartE) begin
        accept    = 1'b1;
        StallMdvE = 1'b1;
        if (fast)            state_nxt = DONE;
        else if (Funct3E[2]) state_nxt = DIV;
        else                 state_nxt = MUL;
      end
      MUL, DIV: begin
        StallMdvE = 1'b1;
        if (cnt == 5'd31) state_nxt = DONE;
      end
      DONE: begin
        MdvValidE = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (FlushE || rst) begin
      state_nxt = IDLE;
      StallMdvE = 1'b0;
      MdvValidE = 1'b0;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op         <= 3'd0;
      cnt        <= 5'd0;
      acc        <= 64'd0;
      opb        <= 32'd0;
      neg        <= 1'b0;
      MdvResultE <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op  <= Funct3E;
        cnt <= 5'd0;
        acc <= {32'd0, Funct3E[2] ? a_mag : b_mag};
        opb <= Funct3E[2] ? b_mag : a_mag;
        // Remainder takes the dividend's sign; everything else the product/quotient sign.
        neg <= (Funct3E[2] && Funct3E[1]) ? a_neg : (a_neg ^ b_neg);
        if (fast) MdvResultE <= fast_res;
      end else if ((state == MUL || state == DIV) && !FlushE) begin
        acc <= (state == MUL) ? acc_mul : acc_div;
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) MdvResultE <= fin;
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table of M ops, then flush, reset and hold sequences.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StartE = 1'b0;
  logic        FlushE = 1'b0;
  logic [2:0]  Funct3E = 3'd0;
  logic [31:0] SrcAE = 32'd0;
  logic [31:0] SrcBE = 32'd0;
  logic        StallMdvE, MdvValidE;
  logic [31:0] MdvResultE;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  mdu_seq dut (
    .clk(clk), .rst(rst), .StartE(StartE), .FlushE(FlushE), .Funct3E(Funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .StallMdvE(StallMdvE), .MdvValidE(MdvValidE),
    .MdvResultE(MdvResultE), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stalls;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one op (held while stalled, operands scrambled after accept) and checks
  // the result, the stall count and that stall is low in the valid cycle.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
    int stalls;
    bit got;
    logic [31:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    StartE = 1'b1; FlushE = 1'b0; Funct3E = f3; SrcAE = a; SrcBE = b;
    stalls = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      if (MdvValidE) begin
        got = 1'b1;
        e = exp_q.pop_front();
        check({name, " result"}, MdvResultE, e);
        check({name, " stalls"}, 32'(stalls), 32'(exp_stalls));
        check({name, " stall_in_done"}, {31'd0, StallMdvE}, 32'd0);
      end else begin
        if (StallMdvE) stalls++;
        @(negedge clk);
        SrcAE = $urandom;
        SrcBE = $urandom;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got no valid pulse expected one within 60 cycles", name);
      exp_q.delete();
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    StartE = 1'b0; FlushE = 1'b0;
  endtask

  initial begin
    int pulses;
    logic [31:0] last;

    vecs.push_back('{"mul_7x-3",      3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{"mulhu_ff",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{"mulh_ff",       3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33});
    vecs.push_back('{"mulhsu_-1x2",   3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{"mul_shift",     3'b000, 32'h1234_5678, 32'h10,        32'h2345_6780, 33});
    vecs.push_back('{"div_-7/2",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{"rem_-7/2",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{"div_7/-2",      3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
    vecs.push_back('{"rem_7/-2",      3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33});
    vecs.push_back('{"divu_100/7",    3'b101, 32'd100,       32'd7,         32'd14,        33});
    vecs.push_back('{"remu_100/7",    3'b111, 32'd100,       32'd7,         32'd2,         33});
    vecs.push_back('{"divu_min/-1",   3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33});
    vecs.push_back('{"divu_5/0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{"remu_5/0",      3'b111, 32'd5,         32'd0,         32'd5,         1});
    vecs.push_back('{"rem_-5/0",      3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1});
    vecs.push_back('{"div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{"rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});

    // Reset state, with a pending start that must not raise stall.
    StartE = 1'b1;
    #12;
    check("rst_stall", {31'd0, StallMdvE}, 32'd0);
    check("rst_valid", {31'd0, MdvValidE}, 32'd0);
    check("rst_result", MdvResultE, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    StartE = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Table ops run back to back: each start lands in the cycle after DONE.
    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stalls);
    last = vecs[vecs.size()-1].exp;
    go_idle();
    #1;
    check("hold_result", MdvResultE, last);
    check("hold_valid", {31'd0, MdvValidE}, 32'd0);

    // Flush at iteration 10: no pulse, result untouched.
    @(negedge clk);
    StartE = 1'b1; Funct3E = 3'b100; SrcAE = 32'd100; SrcBE = 32'd7;
    repeat (10) @(negedge clk);
    FlushE = 1'b1;
    #1;
    check("flush_stall", {31'd0, StallMdvE}, 32'd0);
    check("flush_valid", {31'd0, MdvValidE}, 32'd0);
    go_idle();
    #1;
    check("flush_state", {30'd0, state_dbg}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (MdvValidE) pulses++;
    end
    check("flush_pulses", 32'(pulses), 32'd0);
    check("flush_result", MdvResultE, last);
    run_op("mul_after_flush", 3'b000, 32'd6, 32'd7, 32'd42, 33);

    // Reset at iteration 20 of a MUL, then a clean MUL on the first clock after release.
    @(negedge clk);
    StartE = 1'b1; Funct3E = 3'b000; SrcAE = 32'h1234; SrcBE = 32'h5678;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_stall", {31'd0, StallMdvE}, 32'd0);
    check("midrst_valid", {31'd0, MdvValidE}, 32'd0);
    check("midrst_result", MdvResultE, 32'd0);
    check("midrst_state", {30'd0, state_dbg}, 32'd0);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (MdvValidE) pulses++;
    end
    StartE = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    run_op("mul_3x4_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33);
    check("midrst_pulses", 32'(pulses), 32'd0);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
